// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC select and IF/ID register.
// Define IF_STAGE_INT_EN to build in interrupt entry, eret and the epc register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] INT_VEC  = 32'h0000_0030
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        eret,
    input  logic        int_req,
    output logic [31:0] pc_out,
    input  logic [31:0] inst_in,
    output logic        if_id_valid,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        int_ack,
    output logic [31:0] epc
);

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
    } if_id_t;

    localparam if_id_t BUBBLE = '0;

    logic [31:0] pc;
    logic [31:0] pc_seq;
    logic [31:0] pc_nxt;
    logic [31:0] epc_q;
    logic        int_ack_q;
    if_id_t      if_id;

    logic sel_br;
    logic sel_jump;
    logic sel_eret;
    logic sel_int;
    logic sel_hold;
    logic sel_seq;
    logic redirect;

    assign pc_seq = pc + 32'd4;

    // One-hot selects so the decoder below sees exclusive arms
    assign sel_br   = br_taken;
    assign sel_jump = jump & ~br_taken;

`ifdef IF_STAGE_INT_EN
    logic int_mask;

    assign sel_eret = eret & ~br_taken & ~jump;
    assign sel_int  = int_req & ~int_mask & ~stall
                    & ~br_taken & ~jump & ~eret;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            epc_q     <= 32'h0;
            int_mask  <= 1'b0;
            int_ack_q <= 1'b0;
        end else begin
            int_ack_q <= sel_int;
            if (sel_int) begin
                epc_q    <= pc;
                int_mask <= 1'b1;
            end else if (sel_eret) begin
                int_mask <= 1'b0;
            end
        end
    end
`else
    logic unused_int;

    assign unused_int = int_req ^ eret;
    assign sel_eret   = 1'b0;
    assign sel_int    = 1'b0;
    assign epc_q      = 32'h0;
    assign int_ack_q  = 1'b0;
`endif

    assign redirect = sel_br | sel_jump | sel_eret;
    assign sel_hold = stall & ~redirect & ~sel_int;
    assign sel_seq  = ~(redirect | sel_int | sel_hold);

    always_comb begin
        pc_nxt = pc_seq;
        unique case (1'b1)
            sel_br:   pc_nxt = br_target;
            sel_jump: pc_nxt = jump_target;
            sel_eret: pc_nxt = epc_q;
            sel_int:  pc_nxt = INT_VEC;
            sel_hold: pc_nxt = pc;
            default:  pc_nxt = pc_seq;
        endcase
        pc_nxt[1:0] = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc    <= {RESET_PC[31:2], 2'b00};
            if_id <= BUBBLE;
        end else begin
            pc <= pc_nxt;
            if (redirect | sel_int) begin
                if_id <= BUBBLE;
            end else if (sel_seq) begin
                if_id <= {1'b1, inst_in, pc, pc_seq};
            end
        end
    end

    assign pc_out      = pc;
    assign if_id_valid = if_id.valid;
    assign if_id_inst  = if_id.inst;
    assign if_id_pc    = if_id.pc;
    assign if_id_pc4   = if_id.pc4;
    assign int_ack     = int_ack_q;
    assign epc         = epc_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: reference model of the fetch rules checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_if_stage;

`ifdef IF_STAGE_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif
    localparam logic [31:0] VEC = 32'h0000_0030;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        eret;
    logic        int_req;
    logic [31:0] pc_out;
    logic [31:0] inst_in;
    logic        if_id_valid;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        int_ack;
    logic [31:0] epc;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;

    logic [31:0] m_pc, m_inst, m_ipc, m_pc4, m_epc;
    logic        m_valid, m_ack, m_mask;

    if_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .br_taken(br_taken), .br_target(br_target),
        .jump(jump), .jump_target(jump_target),
        .eret(eret), .int_req(int_req),
        .pc_out(pc_out), .inst_in(inst_in),
        .if_id_valid(if_id_valid), .if_id_inst(if_id_inst),
        .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
        .int_ack(int_ack), .epc(epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign inst_in = mem(pc_out);

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bubble();
        m_valid = 1'b0;
        m_inst = 32'h0;
        m_ipc = 32'h0;
        m_pc4 = 32'h0;
    endtask

    // Reference model: the fetch rules applied once per rising edge
    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc = 32'h0;
            bubble();
            m_epc = 32'h0;
            m_mask = 1'b0;
            m_ack = 1'b0;
        end else begin
            m_ack = 1'b0;
            if (br_taken) begin
                m_pc = br_target & ~32'h3;
                bubble();
            end else if (jump) begin
                m_pc = jump_target & ~32'h3;
                bubble();
            end else if (INT_EN && eret) begin
                m_pc = m_epc;
                m_mask = 1'b0;
                bubble();
            end else if (INT_EN && int_req && !m_mask && !stall) begin
                m_epc = m_pc;
                m_pc = VEC;
                m_mask = 1'b1;
                m_ack = 1'b1;
                bubble();
            end else if (!stall) begin
                m_valid = 1'b1;
                m_inst = mem(m_pc);
                m_ipc = m_pc;
                m_pc4 = m_pc + 32'd4;
                m_pc = m_pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc_out", pc_out, m_pc);
            check("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
            check("if_id_inst", if_id_inst, m_inst);
            check("if_id_pc", if_id_pc, m_ipc);
            check("if_id_pc4", if_id_pc4, m_pc4);
            check("int_ack", {31'h0, int_ack}, {31'h0, m_ack});
            check("epc", epc, m_epc);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 0; stall = 0; br_taken = 0; br_target = 0;
        jump = 0; jump_target = 0; eret = 0; int_req = 0;
        cyc();
        chk_en = 1;
        cyc();
        check("rst_pc", pc_out, 32'h0);
        check("rst_valid", {31'h0, if_id_valid}, 32'h0);
        check("rst_epc", epc, 32'h0);

        rst_n = 1;
        cyc();
        check("f1_pc", pc_out, 32'h4);
        check("f1_ifpc", if_id_pc, 32'h0);
        check("f1_inst", if_id_inst, 32'h0000_FFFF);
        check("f1_valid", {31'h0, if_id_valid}, 32'h1);
        cyc();
        check("f2_pc", pc_out, 32'h8);

        stall = 1;
        repeat (3) begin
            cyc();
            check("stall_pc", pc_out, 32'h8);
            check("stall_ifpc", if_id_pc, 32'h4);
        end
        stall = 0;
        cyc();
        check("unstall_ifpc", if_id_pc, 32'h8);
        check("unstall_inst", if_id_inst, 32'h0008_FFF7);
        check("unstall_pc", pc_out, 32'hC);

        stall = 1; br_taken = 1; br_target = 32'h13;
        cyc();
        check("br_stall_pc", pc_out, 32'h10);
        check("br_stall_valid", {31'h0, if_id_valid}, 32'h0);
        check("br_stall_inst", if_id_inst, 32'h0);

        stall = 0; br_target = 32'h40; jump = 1; jump_target = 32'h80;
        cyc();
        check("br_jump_pc", pc_out, 32'h40);

        br_taken = 0; jump_target = 32'hFFFF_FFFE;
        cyc();
        check("jump_pc", pc_out, 32'hFFFF_FFFC);
        jump = 0;
        cyc();
        check("wrap_pc", pc_out, 32'h0);
        check("wrap_pc4", if_id_pc4, 32'h0);
        check("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);

`ifdef IF_STAGE_INT_EN
        jump = 1; jump_target = 32'h14;
        cyc();
        jump = 0;
        check("to14_pc", pc_out, 32'h14);
        int_req = 1;
        cyc();
        check("int_ack1", {31'h0, int_ack}, 32'h1);
        check("int_epc", epc, 32'h14);
        check("int_pc", pc_out, 32'h30);
        cyc();
        check("int_ack0", {31'h0, int_ack}, 32'h0);
        check("noreent_pc", pc_out, 32'h34);
        eret = 1;
        cyc();
        eret = 0;
        check("eret_pc", pc_out, 32'h14);
        check("eret_ack", {31'h0, int_ack}, 32'h0);
        cyc();
        check("reacc_ack", {31'h0, int_ack}, 32'h1);
        check("reacc_pc", pc_out, 32'h30);
        eret = 1; int_req = 0;
        cyc();
        eret = 0;
        int_req = 1; stall = 1;
        repeat (2) begin
            cyc();
            check("defer_ack", {31'h0, int_ack}, 32'h0);
            check("defer_pc", pc_out, 32'h14);
        end
        stall = 0;
        cyc();
        check("defer_acc", {31'h0, int_ack}, 32'h1);
        check("defer_accpc", pc_out, 32'h30);
        stall = 1; rst_n = 0;
        cyc();
        check("isr_rst_epc", epc, 32'h0);
        check("isr_rst_pc", pc_out, 32'h0);
        check("isr_rst_ack", {31'h0, int_ack}, 32'h0);
        rst_n = 1; stall = 0;
        cyc();
        check("post_rst_ack", {31'h0, int_ack}, 32'h1);
        check("post_rst_pc", pc_out, 32'h30);
        int_req = 0;
`else
        int_req = 1;
        cyc();
        check("noint_pc", pc_out, 32'h4);
        check("noint_ack", {31'h0, int_ack}, 32'h0);
        eret = 1;
        cyc();
        check("noeret_pc", pc_out, 32'h8);
        check("noeret_epc", epc, 32'h0);
        eret = 0; int_req = 0;
        stall = 1;
        cyc();
        rst_n = 0;
        cyc();
        check("stall_rst_pc", pc_out, 32'h0);
        check("stall_rst_valid", {31'h0, if_id_valid}, 32'h0);
        rst_n = 1; stall = 0;
        cyc();
        check("post_rst_pc", pc_out, 32'h4);
        check("post_rst_ifpc", if_id_pc, 32'h0);
`endif
        for (int i = 0; i < 12; i++) begin
            stall = (i % 4) == 1;
            br_taken = i == 6;
            br_target = 32'h200;
            cyc();
        end
        br_taken = 0; stall = 0;
        cyc();
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter: INT_VEC, 32'h0000_0030, interrupt handler entry address.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  in  1  synchronous, active-low reset.
REQ-005 Port: stall  in  1  hazard hold from decode; freezes PC and the IF/ID register.
REQ-006 Port: br_taken  in  1  branch-resolved-taken redirect.
REQ-007 Port: br_target  in  32  branch destination.
REQ-008 Port: jump  in  1  jump redirect.
REQ-009 Port: jump_target  in  32  jump destination.
REQ-010 Port: eret  in  1  return from interrupt.
REQ-011 Port: int_req  in  1  level-sensitive external interrupt request.
REQ-012 Port: pc_out  out  32  fetch address to the byte-addressed, big-endian instruction memory.
REQ-013 Port: inst_in  in  32  combinational instruction word returned for pc_out.
REQ-014 Port: if_id_valid  out  1  IF/ID register holds a real instruction.
REQ-015 Port: if_id_inst  out  32  latched instruction; 32'h0000_0000 (NOP) when not valid.
REQ-016 Port: if_id_pc  out  32  address of the latched instruction.
REQ-017 Port: if_id_pc4  out  32  if_id_pc + 4.
REQ-018 Port: int_ack  out  1  one-cycle pulse on interrupt acceptance.
REQ-019 Port: epc  out  32  saved return address.

Function
REQ-020 pc_out SHALL be driven directly from the PC register; fetch latency is 0 cycles to inst_in and 1 cycle to the IF/ID outputs.
REQ-021 Bits [1:0] of every PC target SHALL be forced to 2'b00; pc_out[1:0] is always 0.
REQ-022 Next-PC priority SHALL be: br_taken > jump > eret > interrupt accept > stall hold > PC+4.
REQ-023 PC+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0000_0000; if_id_pc4 wraps the same way.
REQ-024 Redirect (br_taken, jump or eret): PC <= target (eret target is epc); IF/ID <= bubble (valid 0, inst 0, pc 0, pc4 0).
REQ-025 Redirect SHALL override stall in the same cycle.
REQ-026 Stall without redirect or interrupt: PC and all IF/ID fields hold their values.
REQ-027 Normal cycle: IF/ID <= {valid 1, inst_in, pc_out, pc_out+4}; PC <= PC+4.
REQ-028 Interrupt accept condition: int_req=1, int_mask=0, stall=0 and no redirect.
REQ-029 On interrupt accept: epc <= current PC (the instruction not issued); PC <= INT_VEC; IF/ID <= bubble; int_ack=1 for exactly that next cycle; int_mask <= 1.
REQ-030 int_mask SHALL be cleared by eret; int_req held high while int_mask=1 SHALL be ignored.
REQ-031 If int_req and stall are both high, acceptance SHALL be deferred to the first unstalled, non-redirect cycle.
REQ-032 eret with int_req=1 in the same cycle: eret SHALL win; the interrupt becomes acceptable from the next cycle.

Reset
REQ-033 While rst_n=0 at a clock edge: PC <= RESET_PC; if_id_valid, if_id_inst, if_id_pc, if_id_pc4 <= 0; epc <= 0; int_mask <= 0; int_ack <= 0.
REQ-034 Reset SHALL dominate every other input, including assertion mid-stall or mid-interrupt; the first fetch after release is at RESET_PC.

Configuration
REQ-035 Macro IF_STAGE_INT_EN: when defined, REQ-028..REQ-032 interrupt logic and the epc register are compiled in.
REQ-036 Without IF_STAGE_INT_EN: int_req and eret are ignored, int_ack ties to 0, epc ties to 0, and REQ-022 reduces to br_taken > jump > stall > PC+4.

Verification
REQ-037 Reset release, no stall, memory returning word W at 0 -> pc_out sequence 0,4,8; after the first edge, if_id_pc=0, if_id_inst=W, if_id_valid=1.
REQ-038 stall=1 for 3 cycles at PC=8 -> pc_out stays 8; IF/ID holds the pc=4 entry; the pc=8 entry is latched in the cycle after stall drops.
REQ-039 br_taken=1, br_target=32'h0000_0013, stall=1 in the same cycle -> next pc_out=32'h10, if_id_valid=0; br_taken+jump together -> br_target wins.
REQ-040 PC=32'hFFFF_FFFC, no stall -> next pc_out=0, if_id_pc4=0.
REQ-041 With IF_STAGE_INT_EN, int_req=1 at PC=32'h14 -> int_ack pulses for 1 cycle, epc=32'h14, pc_out=32'h30; int_req kept high gives no re-entry; eret -> pc_out=32'h14, and the interrupt is re-accepted on the following cycle.
REQ-042 Assert rst_n=0 during interrupt service -> epc=0, int_mask=0, pc_out=RESET_PC after the edge.
